registry_cfg_ctrl: RTL and testbench
====================================

# registry_cfg_ctrl

Configuration controller that sequences parameter loads into the acceptance-filter/bit-timing registry. Arbitrates field-level write requests from NUM_REQ requesters (e.g. host config port, CAN-SEC key manager), merges them into a 256-bit shadow configuration word, drives that word plus a single-cycle `param_ld` strobe into the registry, and holds the word stable until the registry has synchronised and latched it before acknowledging the requester.

## Interface
- NUM_REQ, 2, number of requesters (1..8)
- SETTLE_CYC, 4, cycles `data_out` is held after the `param_ld` strobe before ack (≥1; 4 covers the registry's 2-stage strobe sync plus its load state)
- clk  in  1  system clock
- g_rst  in  1  reset; synchronous, active-high
- req  in  NUM_REQ  per-requester load request, level
- we  in  3*NUM_REQ  per-requester field enables {code, mask, sjw}, bit 2 = code
- wdata_code  in  11*NUM_REQ  identifier code field
- wdata_mask  in  11*NUM_REQ  identifier mask field
- wdata_sjw  in  2*NUM_REQ  synchronisation jump width
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- busy  out  1  transaction in progress
- data_out  out  256  configuration word to registry `data_in`
- param_ld  out  1  load strobe to registry

## Operation
- Shadow word layout: code at [255:245], mask at [170:160], sjw at [159:158]; all other bits held 0.
- States: IDLE, DRIVE, SETTLE, ACK.
- IDLE: if any `req` is high, grant one requester (see Configuration), capture its `we`/wdata into the shadow (only enabled fields updated; others keep previous value), go to DRIVE. No request → stay.
- DRIVE: `param_ld`=1 for exactly this cycle; `data_out` already carries the updated shadow; load counter with SETTLE_CYC-1; go to SETTLE.
- SETTLE: decrement counter; at 0 go to ACK. `data_out` unchanged.
- ACK: `ack[grant]`=1 for this cycle only; go to IDLE.
- `we`=3'b000 with `req`: still performs a full load (re-strobe of unchanged word) and acks.
- Requests arriving while busy wait; no queueing beyond the level `req`.
- `req` dropped mid-transaction: transaction completes, ack still pulses.
- Requester must lower `req` at the edge following `ack`; a `req` still high in the IDLE cycle after ack starts a new transaction.
- Reset outputs: `data_out`=0, shadow=0, `param_ld`=0, `ack`=0, `busy`=0, state IDLE, RR pointer to requester 0.
- Reset mid-transaction: abort immediately, no ack, shadow cleared.

## Timing
- Grant sampled at edge t (IDLE, req high). `data_out` updated and `param_ld`=1 in cycle t+1.
- SETTLE occupies t+2 .. t+1+SETTLE_CYC; `ack` in cycle t+2+SETTLE_CYC (t+6 at default).
- `busy`=1 from t+1 through the ack cycle inclusive; 0 in IDLE.
- Back-to-back: minimum spacing between `param_ld` strobes is SETTLE_CYC+3 cycles.
- All outputs registered; no combinational path from `req`/wdata to any output.
- Counter width: $clog2(SETTLE_CYC+1).

## Configuration
- REGCFG_RR_EN defined: round-robin grant; search starts at index after last granted, wraps at NUM_REQ-1 → 0.
- Undefined: fixed priority, lowest index wins; requester 0 can starve others.

## Structure
- Shared package `registry_pkg`: field bit positions/widths (CODE_MSB/LSB, MASK_MSB/LSB, SJW_MSB/LSB), state enum, default SETTLE_CYC.
- One sub-module `cfg_rr_arbiter`: NUM_REQ request vector → one-hot grant; round-robin pointer behind REGCFG_RR_EN, fixed priority otherwise.

## Test plan
- Reset, then req[0] with we=3'b111, code=11'h5A5, mask=11'h7FF, sjw=2'd2 → `param_ld` pulse at t+1, data_out[255:245]=11'h5A5, [170:160]=11'h7FF, [159:158]=2, ack[0] at t+6, registry outputs match.
- Follow with req[1] we=3'b001 sjw=2'd1 → code/mask unchanged, sjw=1, ack[1] only.
- req[0] and req[1] asserted together and held (RR_EN): grants alternate 0,1,0,1; without macro: 0 repeatedly, req[1] never acked.
- req[0] dropped at t+2 → ack[0] still at t+6, data_out holds new word.
- g_rst asserted at t+3 during SETTLE → next cycle data_out=0, busy=0, no ack; new req after reset loads from zero shadow.
- req with we=3'b000 → `param_ld` strobe, data_out unchanged, ack delivered.

Source files
------------

// File: rtl/registry_pkg.sv
// registry_pkg
// Shared definitions for the registry configuration controller.
//   - Bit positions of the code / mask / sjw fields in the 256-bit
//     configuration word that feeds the registry data_in port.
//   - Controller state encoding.
//   - Default settle time after the param_ld strobe.
//   - pack_cfg(): places the three fields into an otherwise-zero word.
package registry_pkg;

    localparam int CFG_W    = 256;

    localparam int CODE_MSB = 255;
    localparam int CODE_LSB = 245;
    localparam int MASK_MSB = 170;
    localparam int MASK_LSB = 160;
    localparam int SJW_MSB  = 159;
    localparam int SJW_LSB  = 158;

    localparam int CODE_W   = CODE_MSB - CODE_LSB + 1;
    localparam int MASK_W   = MASK_MSB - MASK_LSB + 1;
    localparam int SJW_W    = SJW_MSB - SJW_LSB + 1;

    // 4 cycles covers the registry's 2-stage strobe synchroniser plus its load state.
    localparam int SETTLE_CYC_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_ACK
    } state_t;

    function automatic logic [CFG_W-1:0] pack_cfg(
        input logic [CODE_W-1:0] code,
        input logic [MASK_W-1:0] mask,
        input logic [SJW_W-1:0]  sjw
    );
        logic [CFG_W-1:0] w;
        w                    = '0;
        w[CODE_MSB:CODE_LSB] = code;
        w[MASK_MSB:MASK_LSB] = mask;
        w[SJW_MSB:SJW_LSB]   = sjw;
        return w;
    endfunction

endpackage

// File: rtl/cfg_rr_arbiter.sv
// cfg_rr_arbiter
// Picks one requester out of a request vector and remembers the last grant.
//   clk      system clock
//   g_rst    synchronous active-high reset (clears the remembered grant)
//   req      request vector, NUM_REQ bits
//   take     the controller accepts the current grant this cycle
//   grant    one-hot grant for the current req (combinational, zero if no req)
//   grant_q  one-hot grant captured on the last take
// Build option REGCFG_RR_EN: round-robin, search starts one past the last
// granted index and wraps to 0. Without it: fixed priority, lowest index wins.
module cfg_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               g_rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               take,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] grant_q
);

    int start;
    int best_rank;
    int sel;
    int rank;

    // Each requester gets a rank = distance from the search start; the
    // lowest-ranked active requester wins. Fixed priority is simply start=0.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        start     = 0;
        best_rank = NUM_REQ;
        sel       = 0;
        rank      = 0;
        grant     = '0;
`ifdef REGCFG_RR_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) start = (i + 1) % NUM_REQ;
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            rank = (i - start + NUM_REQ) % NUM_REQ;
            if (req[i] && rank < best_rank) begin
                best_rank = rank;
                sel       = i;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (best_rank < NUM_REQ && i == sel) grant[i] = 1'b1;
        end
    end

    // Reset clears the remembered grant, which points the round-robin search at requester 0.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (g_rst) begin
            grant_q <= '0;
        end else if (take) begin
            grant_q <= grant;
        end
    end

endmodule

// File: rtl/registry_cfg_ctrl.sv
// registry_cfg_ctrl
// Sequences field-level configuration writes into the acceptance-filter /
// bit-timing registry: grant a requester, merge its enabled fields into the
// shadow word, strobe param_ld once, hold data_out for SETTLE_CYC cycles,
// then pulse ack to the granted requester.
//   clk         system clock
//   g_rst       synchronous active-high reset
//   req         per-requester load request (level)
//   we          per-requester field enables {code, mask, sjw}, 3 bits each
//   wdata_code  per-requester 11-bit identifier code
//   wdata_mask  per-requester 11-bit identifier mask
//   wdata_sjw   per-requester 2-bit sync jump width
//   ack         one-cycle completion pulse to the granted requester
//   busy        transaction in progress (DRIVE through ACK)
//   data_out    256-bit configuration word to registry data_in
//   param_ld    single-cycle load strobe to the registry
// Build option REGCFG_RR_EN selects round-robin arbitration (default: fixed priority).
module registry_cfg_ctrl
    import registry_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   g_rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   we,
    input  logic [11*NUM_REQ-1:0]  wdata_code,
    input  logic [11*NUM_REQ-1:0]  wdata_mask,
    input  logic [2*NUM_REQ-1:0]   wdata_sjw,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   busy,
    output logic [CFG_W-1:0]       data_out,
    output logic                   param_ld
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CODE_W-1:0]  code_q;
    logic [MASK_W-1:0]  mask_q;
    logic [SJW_W-1:0]   sjw_q;

    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] gnt_q;
    logic               take;

    logic [2:0]         sel_we;
    logic [CODE_W-1:0]  sel_code;
    logic [MASK_W-1:0]  sel_mask;
    logic [SJW_W-1:0]   sel_sjw;

    assign take = (state == S_IDLE) && (|req);

    cfg_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .g_rst   (g_rst),
        .req     (req),
        .take    (take),
        .grant   (gnt),
        .grant_q (gnt_q)
    );

    // Route the granted requester's enables and write data.
    always_comb begin
        sel_we   = '0;
        sel_code = '0;
        sel_mask = '0;
        sel_sjw  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_we   = we[i*3 +: 3];
                sel_code = wdata_code[i*11 +: 11];
                sel_mask = wdata_mask[i*11 +: 11];
                sel_sjw  = wdata_sjw[i*2 +: 2];
            end
        end
    end

    // The shadow fields are the flops; data_out is just their fixed placement.
    assign data_out = pack_cfg(code_q, mask_q, sjw_q);

    always_ff @(posedge clk) begin
        if (g_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            code_q   <= '0;
            mask_q   <= '0;
            sjw_q    <= '0;
            param_ld <= 1'b0;
            ack      <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        if (sel_we[2]) code_q <= sel_code;
                        if (sel_we[1]) mask_q <= sel_mask;
                        if (sel_we[0]) sjw_q  <= sel_sjw;
                        param_ld <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    param_ld <= 1'b0;
                    cnt      <= CNT_W'(SETTLE_CYC - 1);
                    state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    // Hold data_out while the registry synchronises the strobe.
                    if (cnt == '0) begin
                        ack   <= gnt_q;
                        state <= S_ACK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ACK: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_registry_cfg_ctrl.sv
// tb_registry_cfg_ctrl
// Self-checking bench for registry_cfg_ctrl: directed vector table,
// hand-written multi-cycle sequences (req drop, reset mid-transaction,
// held concurrent requests) and randomized loads against a transaction-level
// reference model. Honours REGCFG_RR_EN for the expected arbitration order.
module tb_registry_cfg_ctrl;

    localparam int NUM_REQ    = 2;
    localparam int SETTLE_CYC = 4;

    logic                  clk;
    logic                  g_rst;
    logic [NUM_REQ-1:0]    req;
    logic [3*NUM_REQ-1:0]  we;
    logic [11*NUM_REQ-1:0] wdata_code;
    logic [11*NUM_REQ-1:0] wdata_mask;
    logic [2*NUM_REQ-1:0]  wdata_sjw;
    logic [NUM_REQ-1:0]    ack;
    logic                  busy;
    logic [255:0]          data_out;
    logic                  param_ld;

    registry_cfg_ctrl #(
        .NUM_REQ    (NUM_REQ),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk        (clk),
        .g_rst      (g_rst),
        .req        (req),
        .we         (we),
        .wdata_code (wdata_code),
        .wdata_mask (wdata_mask),
        .wdata_sjw  (wdata_sjw),
        .ack        (ack),
        .busy       (busy),
        .data_out   (data_out),
        .param_ld   (param_ld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: current field values and the next round-robin start.
    int m_code    = 0;
    int m_mask    = 0;
    int m_sjw     = 0;
    int m_rr_next = 0;

    typedef struct {
        int         idx;
        logic [2:0] we;
        int         code;
        int         mask;
        int         sjw;
        int         e_code;
        int         e_mask;
        int         e_sjw;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] make_word(input int code, input int mask, input int sjw);
        return (256'(code) << 245) | (256'(mask) << 160) | (256'(sjw) << 158);
    endfunction

    function automatic int model_pick(input logic [NUM_REQ-1:0] r);
`ifdef REGCFG_RR_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(m_rr_next + k) % NUM_REQ]) return (m_rr_next + k) % NUM_REQ;
        end
`else
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[i]) return i;
        end
`endif
        return 0;
    endfunction

    // Apply requester g's enabled fields (as currently driven) to the model.
    task automatic model_load(input int g);
        if (we[g*3+2]) m_code = int'(wdata_code[g*11 +: 11]);
        if (we[g*3+1]) m_mask = int'(wdata_mask[g*11 +: 11]);
        if (we[g*3])   m_sjw  = int'(wdata_sjw[g*2 +: 2]);
        m_rr_next = (g + 1) % NUM_REQ;
    endtask

    task automatic drive_req(input int i, input logic [2:0] w, input int code, input int mask, input int sjw);
        we[i*3 +: 3]          = w;
        wdata_code[i*11 +: 11] = 11'(code);
        wdata_mask[i*11 +: 11] = 11'(mask);
        wdata_sjw[i*2 +: 2]    = 2'(sjw);
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            drive_req(i, 3'($urandom_range(0, 7)), int'($urandom_range(0, 2047)),
                      int'($urandom_range(0, 2047)), int'($urandom_range(0, 3)));
        end
    endtask

    // Called at a negedge with the request already driven and the DUT idle.
    // Checks the full DRIVE / SETTLE / ACK timeline and the following IDLE cycle.
    task automatic run_txn(input string tag, input logic [255:0] exp_word,
                           input logic [NUM_REQ-1:0] exp_ack, input int drop_after,
                           input bit release_at_ack);
        @(posedge clk);
        for (int c = 1; c <= SETTLE_CYC + 2; c++) begin
            @(negedge clk);
            check($sformatf("%s t+%0d param_ld", tag, c), 256'(param_ld), 256'(c == 1));
            check($sformatf("%s t+%0d busy", tag, c), 256'(busy), 256'(1'b1));
            check($sformatf("%s t+%0d data_out", tag, c), data_out, exp_word);
            check($sformatf("%s t+%0d ack", tag, c), 256'(ack),
                  (c == SETTLE_CYC + 2) ? 256'(exp_ack) : 256'(0));
            if (c == drop_after) req = '0;
            if (c == SETTLE_CYC + 2 && release_at_ack) req = '0;
        end
        @(negedge clk);
        check($sformatf("%s idle busy", tag), 256'(busy), 256'(0));
        check($sformatf("%s idle ack", tag), 256'(ack), 256'(0));
        check($sformatf("%s idle param_ld", tag), 256'(param_ld), 256'(0));
    endtask

    initial begin
        int g;
        int arb_seq[4];
        logic [NUM_REQ-1:0] r;

        // Directed vectors: single requester each, expected fields hand-computed.
        tbl[0] = '{0, 3'b111, 'h5A5, 'h7FF, 2, 'h5A5, 'h7FF, 2};
        tbl[1] = '{1, 3'b001, 'h000, 'h000, 1, 'h5A5, 'h7FF, 1};
        tbl[2] = '{0, 3'b000, 'h3FF, 'h001, 3, 'h5A5, 'h7FF, 1};
        tbl[3] = '{1, 3'b100, 'h123, 'h456, 0, 'h123, 'h7FF, 1};
        tbl[4] = '{0, 3'b010, 'h700, 'h055, 3, 'h123, 'h055, 1};

`ifdef REGCFG_RR_EN
        arb_seq = '{0, 1, 0, 1};
`else
        arb_seq = '{0, 0, 0, 0};
`endif

        g_rst      = 1'b1;
        req        = '0;
        we         = '0;
        wdata_code = '0;
        wdata_mask = '0;
        wdata_sjw  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset data_out", data_out, 256'(0));
        check("reset busy", 256'(busy), 256'(0));
        check("reset ack", 256'(ack), 256'(0));
        check("reset param_ld", 256'(param_ld), 256'(0));
        g_rst = 1'b0;

        // Table-driven loads; the other requester carries random, unrequested data.
        for (int n = 0; n < 5; n++) begin
            randomize_inputs();
            drive_req(tbl[n].idx, tbl[n].we, tbl[n].code, tbl[n].mask, tbl[n].sjw);
            req = '0;
            req[tbl[n].idx] = 1'b1;
            run_txn($sformatf("vec%0d", n), make_word(tbl[n].e_code, tbl[n].e_mask, tbl[n].e_sjw),
                    NUM_REQ'(1) << tbl[n].idx, 0, 1'b1);
            m_code    = tbl[n].e_code;
            m_mask    = tbl[n].e_mask;
            m_sjw     = tbl[n].e_sjw;
            m_rr_next = (tbl[n].idx + 1) % NUM_REQ;
        end

        // req[0] dropped after the strobe cycle: the load still completes and acks.
        randomize_inputs();
        drive_req(0, 3'b111, 'h3C3, 'h0F0, 3);
        req = 2'b01;
        model_load(0);
        run_txn("drop", make_word(m_code, m_mask, m_sjw), 2'b01, 1, 1'b1);

        // Reset asserted during SETTLE: abort with no ack and a cleared shadow.
        randomize_inputs();
        drive_req(0, 3'b111, 'h7E7, 'h111, 1);
        req = 2'b01;
        @(posedge clk);
        @(negedge clk);
        check("abort strobe", 256'(param_ld), 256'(1));
        @(negedge clk);
        @(negedge clk);
        g_rst = 1'b1;
        req   = '0;
        @(negedge clk);
        check("abort data_out", data_out, 256'(0));
        check("abort busy", 256'(busy), 256'(0));
        check("abort ack", 256'(ack), 256'(0));
        check("abort param_ld", 256'(param_ld), 256'(0));
        g_rst     = 1'b0;
        m_code    = 0;
        m_mask    = 0;
        m_sjw     = 0;
        m_rr_next = 0;
        for (int c = 0; c < SETTLE_CYC + 2; c++) begin
            @(negedge clk);
            check($sformatf("post-abort c%0d ack", c), 256'(ack), 256'(0));
            check($sformatf("post-abort c%0d busy", c), 256'(busy), 256'(0));
        end

        // First load after reset starts from an all-zero shadow.
        randomize_inputs();
        drive_req(1, 3'b001, 'h6AA, 'h155, 3);
        req = 2'b10;
        model_load(1);
        run_txn("post-reset", make_word(0, 0, 3), 2'b10, 0, 1'b1);

        // Both requesters held high: grant order depends on the arbitration mode.
        randomize_inputs();
        drive_req(0, 3'b100, 'h111, 0, 0);
        drive_req(1, 3'b100, 'h222, 0, 0);
        req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            model_load(arb_seq[n]);
            run_txn($sformatf("arb%0d", n), make_word(m_code, m_mask, m_sjw),
                    NUM_REQ'(1) << arb_seq[n], 0, n == 3);
        end

        // Randomized loads against the model.
        for (int n = 0; n < 20; n++) begin
            randomize_inputs();
            r   = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            req = r;
            g   = model_pick(r);
            model_load(g);
            run_txn($sformatf("rnd%0d", n), make_word(m_code, m_mask, m_sjw),
                    NUM_REQ'(1) << g, int'($urandom_range(0, 3)), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
